// File: rtl/lsu_aligned.sv
// lsu_aligned: single-outstanding load/store unit with byte/half/word lane steering.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned and illegal-size
// accesses; otherwise offsets are forced aligned and o_fault stays 0.
module lsu_aligned #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic        o_resp_valid,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_mem_req,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_mask,
    input  logic [31:0] i_mem_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sign_ext;
    logic        we;
    logic [2:0]  cnt;
    logic [1:0]  in_off;
    logic [3:0]  in_mask;
    logic [31:0] in_wdata;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        in_fault;
    logic        pend;
`endif

    assign o_req_ready = state == IDLE;

    // Effective lane offset, mask and lane-replicated store data for an incoming request
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        in_off   = i_addr[1:0];
        in_fault = (i_size == 2'b01 && i_addr[0]) || (i_size == 2'b10 && i_addr[1:0] != 2'b00) || i_size == 2'b11;
`else
        in_off   = i_size == 2'b01 ? {i_addr[1], 1'b0} : i_size[1] ? 2'b00 : i_addr[1:0];
`endif
        in_mask  = i_size == 2'b00 ? 4'b0001 << in_off : i_size == 2'b01 ? 4'b0011 << in_off : 4'b1111;
        in_wdata = i_size == 2'b00 ? {4{i_wdata[7:0]}} : i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    end

    // Load lane extraction and extension from the returning memory word
    always_comb begin
        ld_b    = i_mem_data[{off, 3'b000} +: 8];
        ld_h    = off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
        ld_data = size == 2'b00 ? {{24{sign_ext & ld_b[7]}}, ld_b}
                : size == 2'b01 ? {{16{sign_ext & ld_h[15]}}, ld_h}
                : i_mem_data;
    end

    // Request FSM with registered memory and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            off          <= '0;
            size         <= '0;
            sign_ext     <= 1'b0;
            we           <= 1'b0;
            cnt          <= '0;
            o_resp_valid <= 1'b0;
            o_rdata      <= '0;
            o_fault      <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_we     <= 1'b0;
            o_mem_mask   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            pend         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        off         <= in_off;
                        size        <= i_size;
                        sign_ext    <= i_sign_ext;
                        we          <= i_we;
                        o_mem_addr  <= i_addr[31:2];
                        o_mem_wdata <= in_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (in_fault) begin
                            state <= RESP;
                            pend  <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            o_mem_req  <= 1'b1;
                            o_mem_we   <= i_we;
                            o_mem_mask <= in_mask;
                        end
`else
                        state      <= ISSUE;
                        o_mem_req  <= 1'b1;
                        o_mem_we   <= i_we;
                        o_mem_mask <= in_mask;
`endif
                    end
                end
                ISSUE: begin
                    o_mem_req  <= 1'b0;
                    o_mem_we   <= 1'b0;
                    o_mem_mask <= '0;
                    cnt        <= 3'(MEM_LAT - 1);
                    if (we) begin
                        state        <= RESP;
                        o_resp_valid <= 1'b1;
                        o_rdata      <= '0;
                        o_fault      <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state        <= RESP;
                        o_resp_valid <= 1'b1;
                        o_rdata      <= ld_data;
                        o_fault      <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    // A fault spends one silent RESP cycle so its pulse lands at the same point as a store's
                    if (pend) begin
                        pend         <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_rdata      <= '0;
                        o_fault      <= 1'b1;
                    end else begin
                        o_resp_valid <= 1'b0;
                        state        <= IDLE;
                    end
`else
                    o_resp_valid <= 1'b0;
                    state        <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_aligned.sv
// tb_lsu_aligned: directed self-checking bench for lsu_aligned with MEM_LAT=2.
module tb_lsu_aligned;
    localparam int LAT = 2;
    localparam logic [31:0] WORD = 32'h8077F0A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [1:0]  size = '0;
    logic        sext = 1'b0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data;
    int          tests = 0;
    int          fails = 0;
    int          pcnt = 0;
    logic [29:0] maddr = '0;

    lsu_aligned #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_addr(addr), .i_wdata(wdata), .i_we(we), .i_size(size), .i_sign_ext(sext),
        .o_resp_valid(resp_valid), .o_rdata(rdata), .o_fault(fault),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_we(mem_we), .o_mem_mask(mem_mask), .i_mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: read word is valid only in the cycle ISSUE+LAT, garbage otherwise
    always @(posedge clk) begin
        if (mem_req && !mem_we) begin
            pcnt  <= 1;
            maddr <= mem_addr;
        end else if (pcnt == LAT) begin
            pcnt <= 0;
        end else if (pcnt != 0) begin
            pcnt <= pcnt + 1;
        end
    end
    assign mem_data = (pcnt == LAT) ? ((maddr == 30'h400) ? WORD : 32'h0) : 32'h5A5A5A5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] emask,
                          input logic [31:0] ewd, input int elat, input logic [31:0] erd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        chk({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, ".mem_addr"}, {2'b0, mem_addr}, {2'b0, a[31:2]});
        chk({tag, ".mask"}, {28'b0, mem_mask}, {28'b0, emask});
        chk({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, w});
        if (w) chk({tag, ".wdata"}, mem_wdata, ewd);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 2) chk({tag, ".mem_req_off"}, {31'b0, mem_req}, 32'd0);
        end
        chk({tag, ".latency"}, n, elat);
        chk({tag, ".rdata"}, rdata, erd);
        chk({tag, ".fault"}, {31'b0, fault}, 32'd0);
        @(negedge clk);
        chk({tag, ".pulse"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
        chk({tag, ".rdata_hold"}, rdata, erd);
    endtask

    initial begin
        int n;
        logic seen;
        #2;
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst.mask", {28'b0, mem_mask}, 32'd0);
        chk("rst.mem_addr", {2'b0, mem_addr}, 32'd0);
        chk("rst.ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_req("lb",  1'b0, 2'b00, 1'b1, 32'h1001, 32'h0, 4'b0010, 32'h0, 4, 32'hFFFFFFF0);
        do_req("lhu", 1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 4'b1100, 32'h0, 4, 32'h00008077);
        do_req("lh",  1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, 4'b1100, 32'h0, 4, 32'hFFFF8077);
        do_req("lbu", 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 4'b1000, 32'h0, 4, 32'h00000080);
        do_req("lb0", 1'b0, 2'b00, 1'b1, 32'h1000, 32'h0, 4'b0001, 32'h0, 4, 32'hFFFFFFA5);
        do_req("sh",  1'b1, 2'b01, 1'b0, 32'h1002, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF, 2, 32'h0);
        do_req("sb",  1'b1, 2'b00, 1'b0, 32'h1003, 32'h000000C3, 4'b1000, 32'hC3C3C3C3, 2, 32'h0);
        do_req("sw",  1'b1, 2'b10, 1'b0, 32'h1000, 32'h11223344, 4'b1111, 32'h11223344, 2, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h1003;
        @(negedge clk);
        req_valid = 1'b0;
        chk("lw_mis.mem_req", {31'b0, mem_req}, 32'd0);
        chk("lw_mis.early", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("lw_mis.resp", {31'b0, resp_valid}, 32'd1);
        chk("lw_mis.fault", {31'b0, fault}, 32'd1);
        chk("lw_mis.rdata", rdata, 32'd0);
        chk("lw_mis.mem_req2", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        chk("lw_mis.pulse", {31'b0, resp_valid}, 32'd0);
        chk("lw_mis.fault_hold", {31'b0, fault}, 32'd1);
        chk("lw_mis.ready", {31'b0, req_ready}, 32'd1);
`else
        do_req("lw_mis", 1'b0, 2'b10, 1'b0, 32'h1003, 32'h0, 4'b1111, 32'h0, 4, WORD);
        do_req("lh_mis", 1'b0, 2'b01, 1'b0, 32'h1003, 32'h0, 4'b1100, 32'h0, 4, 32'h00008077);
        do_req("sz11",   1'b0, 2'b11, 1'b0, 32'h1001, 32'h0, 4'b1111, 32'h0, 4, WORD);
`endif

        // Reset pulsed while a load is waiting for memory
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h1000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.mem_req", {31'b0, mem_req}, 32'd0);
        chk("abort.resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort.ready", {31'b0, req_ready}, 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("abort.no_resp", {31'b0, seen}, 32'd0);
        do_req("lw_after", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 4'b1111, 32'h0, 4, WORD);

        // Request held high across a whole load
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; size = 2'b00; sext = 1'b1; addr = 32'h1001;
        chk("hold.ready0", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("hold.ready_c1", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("hold.ready_c2", {31'b0, req_ready}, 32'd0);
        chk("hold.no_reissue", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        chk("hold.ready_c3", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("hold.resp", {31'b0, resp_valid}, 32'd1);
        chk("hold.ready_resp", {31'b0, req_ready}, 32'd0);
        chk("hold.rdata", rdata, 32'hFFFFFFF0);
        size = 2'b01; sext = 1'b0; addr = 32'h1002;
        @(negedge clk);
        chk("hold.ready_idle", {31'b0, req_ready}, 32'd1);
        chk("hold.mem_req_idle", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold.second_issue", {31'b0, mem_req}, 32'd1);
        chk("hold.second_mask", {28'b0, mem_mask}, 32'h0000000C);
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold.second_latency", n, 4);
        chk("hold.second_rdata", rdata, 32'h00008077);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_aligned.md
LSU_ALIGNED -- requirements
Module: lsu_aligned

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning read-data latency in cycles from the memory-issue cycle, legal range 1..8.
REQ-002 SHALL have ports `clk` (in, 1) as the single clock and `rst` (in, 1) as an asynchronous, active-high reset.
REQ-003 SHALL have request ports:
- `i_req_valid` (in, 1): request offered.
- `o_req_ready` (out, 1): request accepted when high together with `i_req_valid`.
- `i_addr` (in, 32): byte address.
- `i_wdata` (in, 32): store data, low-aligned.
- `i_we` (in, 1): 1 = store.
- `i_size` (in, 2): 00 byte, 01 half, 10 word, 11 illegal.
- `i_sign_ext` (in, 1): sign-extend loads.
REQ-004 SHALL have response ports:
- `o_resp_valid` (out, 1): single-cycle response pulse.
- `o_rdata` (out, 32): load result, low-aligned and extended.
- `o_fault` (out, 1): misaligned or illegal access.
REQ-005 SHALL have memory ports:
- `o_mem_req` (out, 1): access strobe.
- `o_mem_addr` (out, 30): word address.
- `o_mem_wdata` (out, 32): lane-replicated store data.
- `o_mem_we` (out, 1): write enable.
- `o_mem_mask` (out, 4): byte-lane enables.
- `i_mem_data` (in, 32): read word.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; `o_req_ready` SHALL be 1 only in IDLE.
REQ-007 SHALL register addr/wdata/we/size/sign_ext on acceptance in IDLE, which moves the FSM to ISSUE (or to RESP on fault, see REQ-016).
REQ-008 In ISSUE, SHALL assert `o_mem_req` for exactly one cycle and drive:
- `o_mem_addr` = addr[31:2].
- `o_mem_we` = we.
- `o_mem_mask`: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111, where off = addr[1:0].
REQ-009 SHALL drive `o_mem_wdata` as the byte replicated x4 (byte) or the half replicated x2 (half), otherwise the full word.
REQ-010 Outside ISSUE, `o_mem_req`, `o_mem_we` and `o_mem_mask` SHALL be 0.
REQ-011 ISSUE SHALL move to RESP for stores and to WAIT for loads.
REQ-012 WAIT SHALL count MEM_LAT cycles from ISSUE, then sample `i_mem_data` on the edge ending the cycle ISSUE+MEM_LAT and move to RESP.
REQ-013 For loads, SHALL extract byte lane off or half lane off[1], then zero-extend or sign-extend per `sign_ext` into `o_rdata`.
REQ-014 In RESP, SHALL assert `o_resp_valid` for one cycle, then return to IDLE; there is no response backpressure.
REQ-015 Latency from the acceptance edge SHALL be: store response 2 cycles, load response MEM_LAT+2 cycles; `o_rdata` SHALL be 0 for stores and faults.
REQ-016 Faulting requests SHALL go from IDLE directly to RESP with `o_fault`=1, with no `o_mem_req` issued.
REQ-017 `o_rdata` and `o_fault` SHALL hold their values until the next RESP.
REQ-018 `i_req_valid` while not in IDLE SHALL be ignored (not accepted, no side effect).

Reset
REQ-019 `rst` SHALL force IDLE and 0 on `o_resp_valid`, `o_rdata`, `o_fault`, `o_mem_req`, `o_mem_we`, `o_mem_mask`, `o_mem_addr` and `o_mem_wdata`.
REQ-020 Reset mid-operation SHALL abort the operation with no response; returning read data SHALL be ignored, and `o_req_ready`=1 in the first cycle after release.

Configuration
REQ-021 With `LSU_MISALIGN_TRAP_EN` defined, half with off[0]=1, word with off!=0, and size 11 SHALL fault.
REQ-022 Without `LSU_MISALIGN_TRAP_EN`:
- Offset SHALL be forced: half uses {off[1],0}, word uses 00, size 11 is treated as word.
- `o_fault` SHALL be tied to 0.

Verification
Setup: MEM_LAT=2, memory word 0x400 = 0x8077F0A5.
REQ-023 lb 0x1001 -> ISSUE: addr 0x400, mask 0010; response at acceptance+4, `o_rdata`=0xFFFFFFF0.
REQ-024 lhu 0x1002 -> `o_rdata`=0x00008077, mask 1100; lh 0x1002 -> 0xFFFF8077.
REQ-025 sh 0xBEEF @0x1002 -> mask 1100, wdata 0xBEEFBEEF, we=1; response at acceptance+2, rdata 0.
REQ-026 lw 0x1003 -> with the macro: no `o_mem_req`, fault=1 at acceptance+2; without: mask 1111, rdata 0x8077F0A5, fault=0.
REQ-027 `rst` pulsed in WAIT -> no `o_resp_valid`; ready=1 after release; the next lw 0x1000 returns 0x8077F0A5.
REQ-028 `i_req_valid` held high during a load -> ready=0 until RESP; the second request is accepted in the cycle after RESP.
